// File: rtl/regfile_sequencer_pkg.sv
// Shared constants for the register-file sequencer: opcodes, state encoding,
// instruction field layout and a field-extraction helper.
package regfile_sequencer_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned FIELD_W  = 4;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned DST_LSB  = 8;
  localparam int unsigned SRC1_LSB = 4;
  localparam int unsigned SRC2_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_LDI = 4'hD;
  localparam logic [FIELD_W-1:0] OP_NOP = 4'hF;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB      = 3'd4;

  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] dst;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src2;
  } instr_t;

  function automatic instr_t decodeInstr(input logic [INSTR_W-1:0] raw);
    instr_t f;
    f.opcode = raw[OPC_LSB  +: FIELD_W];
    f.dst    = raw[DST_LSB  +: FIELD_W];
    f.src1   = raw[SRC1_LSB +: FIELD_W];
    f.src2   = raw[SRC2_LSB +: FIELD_W];
    return f;
  endfunction

endpackage

// File: rtl/regfile_sequencer.sv
// Five-state sequencer driving an external register file and combinational ALU:
// read two registers, execute, write back one result per instruction.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] Aaddr,
  output logic [ADDR_W-1:0] Baddr,
  output logic [ADDR_W-1:0] Caddr,
  output logic [DATA_W-1:0] C,
  output logic              load,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done
);

  logic [STATE_W-1:0] state, stateNxt;
  instr_t             cur, curNxt, inF;
  logic [ADDR_W-1:0]  aaddrNxt, baddrNxt, caddrNxt;
  logic [DATA_W-1:0]  cNxt, aluANxt, aluBNxt;
  logic               loadNxt, doneNxt, readyNxt;

  assign inF    = decodeInstr(instr);
  assign alu_op = cur.opcode;

  // Outputs are registered, so each transition computes the values seen in the next state.
  always_comb begin
    stateNxt = state;
    curNxt   = cur;
    aaddrNxt = Aaddr;
    baddrNxt = Baddr;
    caddrNxt = Caddr;
    cNxt     = C;
    aluANxt  = alu_a;
    aluBNxt  = alu_b;
    loadNxt  = 1'b1;
    doneNxt  = 1'b0;
    readyNxt = 1'b0;
    case (state)
      ST_IDLE: begin
        readyNxt = 1'b1;
        if (instr_valid && instr_ready) begin
          curNxt   = inF;
          readyNxt = 1'b0;
          if (inF.opcode == OP_LDI) begin
            stateNxt = ST_WB;
            caddrNxt = ADDR_W'(inF.dst);
            cNxt     = DATA_W'({inF.src1, inF.src2});
            loadNxt  = 1'b0;
            doneNxt  = 1'b1;
          end else begin
            stateNxt = ST_ISSUE;
            aaddrNxt = ADDR_W'(inF.src1);
            baddrNxt = ADDR_W'(inF.src2);
          end
        end
      end
      ST_ISSUE: begin
        stateNxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        stateNxt = ST_EXEC;
        aluANxt  = A;
        aluBNxt  = B;
        doneNxt  = (cur.opcode == OP_NOP);
      end
      ST_EXEC: begin
        if (cur.opcode == OP_NOP) begin
          stateNxt = ST_IDLE;
          readyNxt = 1'b1;
        end else begin
          stateNxt = ST_WB;
          caddrNxt = ADDR_W'(cur.dst);
          cNxt     = alu_result;
          loadNxt  = 1'b0;
          doneNxt  = 1'b1;
        end
      end
      ST_WB: begin
        stateNxt = ST_IDLE;
        readyNxt = 1'b1;
      end
      default: begin
        stateNxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= ST_IDLE;
      cur         <= '0;
      Aaddr       <= '0;
      Baddr       <= '0;
      Caddr       <= '0;
      C           <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      load        <= 1'b1;
      done        <= 1'b0;
      instr_ready <= 1'b0;
    end else begin
      state       <= stateNxt;
      cur         <= curNxt;
      Aaddr       <= aaddrNxt;
      Baddr       <= baddrNxt;
      Caddr       <= caddrNxt;
      C           <= cNxt;
      alu_a       <= aluANxt;
      alu_b       <= aluBNxt;
      load        <= loadNxt;
      done        <= doneNxt;
      instr_ready <= readyNxt;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file and ALU around the DUT,
// directed scenarios followed by random instructions against a register-array model.
module tb_regfile_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          clear;
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [AW-1:0] Aaddr, Baddr, Caddr;
  logic [DW-1:0] C, A, B, alu_a, alu_b, alu_result;
  logic          load, done;
  logic [3:0]    alu_op;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] refRegs [16];
  logic [DW-1:0] rdA, rdB;
  logic          rfInit;

  int cyc = 0, hsCount = 0, doneCount = 0, wrCount = 0, lastHs = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .clear(clear), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .Aaddr(Aaddr), .Baddr(Baddr), .Caddr(Caddr),
    .C(C), .load(load), .A(A), .B(B), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .done(done)
  );

  function automatic logic [DW-1:0] aluModel(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = aluModel(alu_op, alu_a, alu_b);
  assign A = rdA;
  assign B = rdB;

  // Register file: reads on load=1 edges, writes C on load=0 edges.
  always @(posedge clk) begin
    if (rfInit) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (load) begin
      rdA <= mem[Aaddr];
      rdB <= mem[Baddr];
    end else begin
      mem[Caddr] <= C;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && instr_ready) begin
      hsCount <= hsCount + 1;
      lastHs  <= cyc;
    end
    if (done)  doneCount <= doneCount + 1;
    if (!load) wrCount   <= wrCount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one retired instruction.
  task automatic retire(input logic [15:0] ins);
    logic [3:0] op, d, s1, s2;
    logic [DW-1:0] x, y;
    op = ins[15:12]; d = ins[11:8]; s1 = ins[7:4]; s2 = ins[3:0];
    x = refRegs[s1];
    y = refRegs[s2];
    if (op == 4'hD)      refRegs[d] = {8'h00, ins[7:0]};
    else if (op == 4'h0) refRegs[d] = x + y;
    else if (op == 4'h1) refRegs[d] = x - y;
    else if (op == 4'h2) refRegs[d] = x & y;
    else if (op == 4'h3) refRegs[d] = x | y;
    else if (op == 4'h4) refRegs[d] = x ^ y;
    else if (op != 4'hF) refRegs[d] = x;
  endtask

  task automatic checkRegs(input string tag);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== refRegs[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic waitReady();
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
    chk("ready_wait", 32'(instr_ready), 32'd1);
  endtask

  task automatic waitHs(input int target);
    for (int i = 0; i < 20 && hsCount != target; i++) begin
      @(posedge clk);
      #1;
    end
    chk("hs_wait", 32'(hsCount), 32'(target));
  endtask

  // Issue one instruction and check done/load/ready cycle by cycle until it retires.
  task automatic runInstr(input logic [15:0] ins);
    int lat;
    logic [3:0] op;
    op  = ins[15:12];
    lat = (op == 4'hD) ? 1 : (op == 4'hF) ? 3 : 4;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk("done",  32'(done),        32'(k == lat));
      chk("load",  32'(load),        32'(!(k == lat && op != 4'hF)));
      chk("ready", 32'(instr_ready), 32'(k > lat));
    end
    retire(ins);
    checkRegs("regs");
  endtask

  initial begin
    logic [3:0] opList [7];
    int hs0, dn0, wr0, first;
    opList = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'hF};
    for (int i = 0; i < 16; i++) refRegs[i] = '0;
    clear = 1'b0;
    rfInit = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_load",  32'(load),        32'd1);
    chk("rst_done",  32'(done),        32'd0);
    chk("rst_addr",  32'({Aaddr, Baddr, Caddr}), 32'd0);
    chk("rst_data",  32'({C, alu_a}),  32'd0);
    chk("rst_aluop", 32'(alu_op),      32'd0);
    rfInit = 1'b0;
    clear = 1'b1;
    #1 chk("ready_pre_edge", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("ready_rise", 32'(instr_ready), 32'd1);
    checkRegs("regs_init");

    // LDI writes at the first edge after the handshake.
    runInstr(16'hD3A5);
    chk("ldi_r3", 32'(mem[3]), 32'h00A5);

    runInstr(16'hD105);
    runInstr(16'hD207);
    runInstr(16'h0412);
    chk("add_r4", 32'(mem[4]), 32'h000C);

    // R1 = 0 - 1 = FFFF, then R1 = R1 + R2 with dst aliasing src1.
    runInstr(16'hD500);
    runInstr(16'hD601);
    runInstr(16'h1156);
    chk("sub_r1", 32'(mem[1]), 32'hFFFF);
    runInstr(16'hD201);
    runInstr(16'h0112);
    chk("alias_r1", 32'(mem[1]), 32'h0000);

    // valid held high: NOP then ADD, each accepted exactly once.
    runInstr(16'hD105);
    runInstr(16'hD207);
    hs0 = hsCount; dn0 = doneCount; wr0 = wrCount;
    @(negedge clk);
    instr = 16'hF000;
    instr_valid = 1'b1;
    waitHs(hs0 + 1);
    first = lastHs;
    instr = 16'h0412;
    waitHs(hs0 + 2);
    instr_valid = 1'b0;
    chk("hs_gap", 32'(lastHs - first), 32'd4);
    repeat (6) @(negedge clk);
    retire(16'hF000);
    retire(16'h0412);
    chk("bp_hs",    32'(hsCount - hs0),   32'd2);
    chk("bp_done",  32'(doneCount - dn0), 32'd2);
    chk("bp_write", 32'(wrCount - wr0),   32'd1);
    chk("bp_r4",    32'(mem[4]),          32'h000C);
    checkRegs("bp_regs");

    // Reset while in EXEC aborts the ADD into R9.
    @(negedge clk);
    instr = 16'h0945;
    instr_valid = 1'b1;
    waitReady();
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    dn0 = doneCount; wr0 = wrCount;
    clear = 1'b0;
    #1;
    chk("abort_load",  32'(load),        32'd1);
    chk("abort_done",  32'(done),        32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd0);
    chk("abort_out",   32'({Caddr, C}),  32'd0);
    chk("abort_alu",   32'({alu_a, alu_b}), 32'd0);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk("abort_ready_rise", 32'(instr_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("abort_nowrite", 32'(wrCount - wr0),   32'd0);
    chk("abort_nodone",  32'(doneCount - dn0), 32'd0);
    checkRegs("abort_regs");

    for (int r = 0; r < 16; r++) runInstr({4'hD, 4'(r), 8'($urandom)});
    for (int n = 0; n < 40; n++)
      runInstr({opList[$urandom_range(6, 0)], 12'($urandom)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
